// File: rtl/imem_boot.sv
// Instruction memory with a valid/ready boot loader. The core is held in reset
// until a program has been streamed in, and then it is served registered fetches.
module imem_boot #(
    parameter int          DEPTH    = 32,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013,
    localparam int         AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic [AW:0]   ld_len,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   instr,
    output logic          core_rst,
    output logic          busy,
    output logic          done,
    output logic          len_err,
    output logic          fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic [31:0]   instr_q, instr_d;
    logic          core_rst_q, core_rst_d;
    logic          len_err_q, len_err_d;
    logic          fetch_err_q, fetch_err_d;
    logic          mem_we_s;
    logic          len_ok_s;
    logic          pc_bad_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   mem_q [DEPTH];

    assign len_ok_s = (ld_len != {(AW+1){1'b0}}) && (ld_len <= DEPTH_W);
    assign idx_s    = pc[AW+1:2];
    assign pc_bad_s = (pc[1:0] != 2'b00) || (pc[31:AW+2] != {(30-AW){1'b0}});

    // Next-state, loader and fetch decisions
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        instr_d     = instr_q;
        core_rst_d  = core_rst_q;
        len_err_d   = len_err_q;
        fetch_err_d = fetch_err_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                core_rst_d = 1'b1;
                instr_d    = 32'h0000_0000;
                if (ld_start && len_ok_s) begin
                    len_d     = ld_len;
                    cnt_d     = {(AW+1){1'b0}};
                    len_err_d = 1'b0;
                    state_d   = ST_LOAD;
                end else if (ld_start) begin
                    len_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                core_rst_d = 1'b1;
                if (ld_valid) begin
                    mem_we_s = 1'b1;
                    cnt_d    = cnt_q + ONE_W;
                    // Leave on the edge that takes the final word so the core
                    // sees reset low from the first RUN cycle.
                    if (cnt_q == len_q - ONE_W) begin
                        state_d     = ST_RUN;
                        core_rst_d  = 1'b0;
                        fetch_err_d = 1'b0;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (ld_start && len_ok_s) begin
                    len_d      = ld_len;
                    cnt_d      = {(AW+1){1'b0}};
                    len_err_d  = 1'b0;
                    core_rst_d = 1'b1;
                    instr_d    = 32'h0000_0000;
                    state_d    = ST_LOAD;
                end else begin
                    if (ld_start) begin
                        len_err_d = 1'b1;
                    end else begin
                        len_err_d = len_err_q;
                    end
                    if (pc_bad_s) begin
                        instr_d     = NOP_WORD;
                        fetch_err_d = 1'b1;
                    end else if ({1'b0, idx_s} >= len_q) begin
                        instr_d = NOP_WORD;
                    end else begin
                        instr_d = mem_q[idx_s];
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                core_rst_d = 1'b1;
                instr_d    = 32'h0000_0000;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {(AW+1){1'b0}};
            len_q       <= {(AW+1){1'b0}};
            instr_q     <= 32'h0000_0000;
            core_rst_q  <= 1'b1;
            len_err_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            instr_q     <= instr_d;
            core_rst_q  <= core_rst_d;
            len_err_q   <= len_err_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Instruction RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_q[cnt_q[AW-1:0]] <= ld_data;
        end
    end

    assign ld_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD);
    assign done      = (state_q == ST_RUN);
    assign instr     = instr_q;
    assign core_rst  = core_rst_q;
    assign len_err   = len_err_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_imem_boot.sv
// Directed bench for imem_boot: fetch vectors from a table, with hand-written
// sequences covering the load, reload and reset corner cases.
module tb_imem_boot;

    localparam int          DEPTH = 32;
    localparam int          AW    = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_start;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          core_rst;
    logic          busy;
    logic          done;
    logic          len_err;
    logic          fetch_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ferr;
    } fvec_t;

    fvec_t       fv [8];
    logic [31:0] wbuf [8];

    imem_boot #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .pc(pc), .instr(instr), .core_rst(core_rst),
        .busy(busy), .done(done), .len_err(len_err), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_instr"}, instr, 32'h0);
        chk({nm, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_ready"}, {31'd0, ld_ready}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_len_err"}, {31'd0, len_err}, 32'd0);
        chk({nm, "_fetch_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    task automatic start(input int len);
        ld_start = 1'b1;
        ld_len   = AW'(0) + len[AW:0];
        tick();
        ld_start = 1'b0;
    endtask

    // Streams n words from wbuf; toggle inserts idle cycles between words.
    task automatic do_load(input int n, input bit toggle);
        int   acc;
        logic ph;
        acc = 0;
        ph  = 1'b1;
        for (int c = 0; c < 64 && acc < n; c++) begin
            ld_valid = ph;
            ld_data  = wbuf[acc];
            chk("load_busy", {31'd0, busy}, 32'd1);
            chk("load_not_done", {31'd0, done}, 32'd0);
            chk("load_core_rst", {31'd0, core_rst}, 32'd1);
            tick();
            if (ph) acc++;
            ph = toggle ? ~ph : 1'b1;
        end
        ld_valid = 1'b0;
        chk("load_accepted", acc, n);
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_busy_low", {31'd0, busy}, 32'd0);
        chk("load_core_rst_low", {31'd0, core_rst}, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] exp_i, input logic exp_e);
        pc = p;
        tick();
        chk("fetch_instr", instr, exp_i);
        chk("fetch_err", {31'd0, fetch_err}, {31'd0, exp_e});
    endtask

    initial begin
        wbuf[0] = 32'h0050_0093;
        wbuf[1] = 32'h00a0_0113;
        wbuf[2] = 32'h0020_81b3;
        wbuf[3] = 32'h0030_2023;
        wbuf[4] = 32'h0000_2283;
        wbuf[5] = 32'h0;
        wbuf[6] = 32'h0;
        wbuf[7] = 32'h0;
        fv[0] = '{32'h00, 32'h0050_0093, 1'b0};
        fv[1] = '{32'h04, 32'h00a0_0113, 1'b0};
        fv[2] = '{32'h08, 32'h0020_81b3, 1'b0};
        fv[3] = '{32'h0c, 32'h0030_2023, 1'b0};
        fv[4] = '{32'h10, 32'h0000_2283, 1'b0};
        fv[5] = '{32'h14, NOP,           1'b0};
        fv[6] = '{32'h02, NOP,           1'b1};
        fv[7] = '{32'h80, NOP,           1'b1};

        rst = 1'b0; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0;
        ld_data = 32'h0; pc = 32'h0;
        tick(); tick();
        chk_reset_state("reset");
        rst = 1'b1;
        tick();
        chk_reset_state("idle");

        // Contiguous load, then the loaded words come back in order
        start(5);
        do_load(5, 1'b0);
        for (int i = 0; i < 5; i++) fetch(fv[i].pc, fv[i].instr, fv[i].ferr);

        // Reload from RUN with gaps in ld_valid
        start(5);
        chk("reload_core_rst", {31'd0, core_rst}, 32'd1);
        do_load(5, 1'b1);
        for (int i = 0; i < 8; i++) fetch(fv[i].pc, fv[i].instr, fv[i].ferr);

        // Illegal length while running keeps the core going
        start(0);
        chk("run_len0_err", {31'd0, len_err}, 32'd1);
        chk("run_len0_done", {31'd0, done}, 32'd1);

        // Short reload: core_rst rises and done drops on the edge after the pulse
        wbuf[0] = 32'h0010_0093;
        wbuf[1] = 32'h0020_0113;
        start(2);
        chk("r2_core_rst", {31'd0, core_rst}, 32'd1);
        chk("r2_done", {31'd0, done}, 32'd0);
        chk("r2_instr", instr, 32'h0);
        chk("r2_len_err_clr", {31'd0, len_err}, 32'd0);
        do_load(2, 1'b0);
        fetch(32'h4, 32'h0020_0113, 1'b0);
        fetch(32'h8, NOP, 1'b0);
        fetch(32'h0, 32'h0010_0093, 1'b0);

        // Illegal lengths from IDLE
        rst = 1'b0; tick(); rst = 1'b1;
        chk_reset_state("rst2");
        start(0);
        chk("len0_err", {31'd0, len_err}, 32'd1);
        chk("len0_ready", {31'd0, ld_ready}, 32'd0);
        chk("len0_core_rst", {31'd0, core_rst}, 32'd1);
        start(DEPTH + 1);
        chk("len33_err", {31'd0, len_err}, 32'd1);
        chk("len33_busy", {31'd0, busy}, 32'd0);
        chk("len33_done", {31'd0, done}, 32'd0);
        start(5);
        chk("legal_clears_err", {31'd0, len_err}, 32'd0);
        chk("legal_busy", {31'd0, busy}, 32'd1);

        // Reset after three of five words
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = wbuf[i];
            tick();
        end
        chk("mid_load_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_reset_state("mid_load_rst");
        for (int i = 0; i < 4; i++) tick();
        ld_valid = 1'b0;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_ready", {31'd0, ld_ready}, 32'd0);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        chk("post_rst_core_rst", {31'd0, core_rst}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot.md
Name: imem_boot

Overview:
- Instruction-memory stage directly upstream of the single-cycle CORE; supplies `instr` from the PC the core drives.
- Contains a word-addressed instruction RAM plus a boot loader FSM.
- Holds the core in reset while a host streams a program in over a valid/ready port, then releases the core and serves registered fetches.
- Replaces bench-side instruction arrays; the design and bench share one fetch path.

Parameters:
- DEPTH, 32, number of 32-bit instruction words; power of two, min 2.
- AW, $clog2(DEPTH), word-index width; derived, not overridden.
- NOP_WORD, 32'h00000013, word returned for unloaded, out-of-range or misaligned fetches.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset.
- ld_start  in  1  one-cycle pulse; begins a load of ld_len words.
- ld_len  in  AW+1  number of words to load; sampled only when ld_start is accepted.
- ld_valid  in  1  host word valid.
- ld_data  in  32  host instruction word.
- ld_ready  out  1  block accepts a word this cycle.
- pc  in  32  byte address from CORE.
- instr  out  32  fetched instruction to CORE (registered).
- core_rst  out  1  active-high reset to CORE (registered).
- busy  out  1  high in LOAD.
- done  out  1  high in RUN.
- len_err  out  1  sticky; last ld_start carried an illegal length.
- fetch_err  out  1  sticky; a misaligned or out-of-range pc was fetched in RUN.

Behaviour:
- Reset: rst=0 at a clock edge forces
  - state=IDLE, cnt=0, len_q=0, instr=0, core_rst=1;
  - ld_ready=0, busy=0, done=0, len_err=0, fetch_err=0.
  - RAM contents are not reset.
  - Reset overrides every other event, including mid-LOAD and mid-RUN.
- States: IDLE, LOAD, RUN (2-bit register). ld_ready, busy and done are pure decodes of state.
- IDLE:
  - core_rst=1, instr held at 0.
  - ld_start with 1 <= ld_len <= DEPTH: len_q<=ld_len, cnt<=0, len_err<=0, go LOAD.
  - ld_start with ld_len=0 or ld_len>DEPTH: len_err<=1, stay IDLE.
- LOAD:
  - ld_ready=1, core_rst=1.
  - Each cycle with ld_valid & ld_ready: mem[cnt]<=ld_data, cnt<=cnt+1.
  - When the accepted word has cnt==len_q-1, go RUN on the same edge.
  - ld_start is ignored in LOAD.
  - ld_valid=0 stalls indefinitely with no timeout.
- Entering RUN: core_rst<=0 on the edge that enters RUN, so the core sees reset low from the first RUN cycle. fetch_err<=0 on entry.
- RUN fetch (one-cycle latency): each edge computes idx=pc[AW+1:2], then:
  - pc[1:0]!=0: instr<=NOP_WORD, fetch_err<=1.
  - pc[31:AW+2]!=0: instr<=NOP_WORD, fetch_err<=1.
  - idx>=len_q (unloaded): instr<=NOP_WORD, no error.
  - otherwise: instr<=mem[idx].
- RUN reload: ld_start with a legal ld_len re-enters LOAD on that edge.
  - core_rst<=1 and instr<=0 on the same edge.
  - len_q and cnt are reloaded.
  - An illegal ld_len sets len_err and stays in RUN.
- Counter: cnt is AW+1 bits and never exceeds len_q. No write occurs beyond index len_q-1; RAM index wrap is impossible.
- Reads and writes never coincide, because writes occur only in LOAD and reads only in RUN.

Test Plan:
1. Reset, then ld_start with ld_len=5; stream 00500093, 00a00113, 002081b3, 00302023, 00002283 with ld_valid held high.
   - busy=1 for exactly 5 cycles; done=1 and core_rst=0 on the cycle after the 5th accept.
   - pc=0,4,8,12,16 yields those five words, each one cycle after pc is applied.
2. Same load with ld_valid toggled 1,0,1,0…
   - Only cycles with ld_valid=1 advance cnt; RAM contents are identical to scenario 1.
   - RUN is entered after the 5th accepted word only.
3. ld_start with ld_len=0, then with ld_len=DEPTH+1.
   - len_err=1, state stays IDLE, core_rst=1, ld_ready=0.
   - A subsequent legal start clears len_err.
4. In RUN after a 5-word load, apply these pcs:
   - pc=32'h14 (idx 5, unloaded) -> instr=00000013, fetch_err=0.
   - pc=32'h2 -> instr=00000013, fetch_err=1 (sticky).
   - pc=32'h80 -> instr=00000013, fetch_err stays 1.
5. In RUN, pulse ld_start with ld_len=2 and load 00100093, 00200113.
   - core_rst rises on the edge after the pulse; done drops.
   - After two accepts, RUN is re-entered; pc=4 -> 00200113, pc=8 -> 00000013.
6. rst=0 asserted after 3 of 5 words in LOAD.
   - All outputs return to their reset values on that edge; state=IDLE.
   - ld_valid pulses that follow are not accepted.
